// File: rtl/ysyx_25020047_core_ctrl_if.sv
// Handshake and strobe bundle between the sequencing controller and the core datapath.
// The master side is the controller; the slave side is the fetch/decode/LSU/regfile/CSR/PC logic.
interface ysyx_25020047_core_ctrl_if;
  logic [63:0] inst_type;
  logic        ifu_valid;
  logic        lsu_done;
  logic        ifu_req;
  logic        inst_latch_en;
  logic        lsu_req;
  logic        lsu_wen;
  logic        reg_wen;
  logic        csr_wen;
  logic        pc_wen;
  logic        intr;
  logic        mret;
  logic        halt;
  logic [1:0]  halt_code;
  logic [2:0]  state;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  modport master (
    input  inst_type, ifu_valid, lsu_done,
    output ifu_req, inst_latch_en, lsu_req, lsu_wen, reg_wen, csr_wen, pc_wen,
           intr, mret, halt, halt_code, state, mcycle, minstret
  );

  modport slave (
    output inst_type, ifu_valid, lsu_done,
    input  ifu_req, inst_latch_en, lsu_req, lsu_wen, reg_wen, csr_wen, pc_wen,
           intr, mret, halt, halt_code, state, mcycle, minstret
  );
endinterface

// File: rtl/ysyx_25020047_core_ctrl.sv
// Multi-cycle sequencer: FETCH -> DECODE -> (MEM) -> WB/TRAP, with bus-wait timeout,
// sticky halt and the mcycle/minstret counters.
module ysyx_25020047_core_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25020047_core_ctrl_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [63:0] M_LOAD   = 64'h0000_00E0_0000_0060;
  localparam logic [63:0] M_STORE  = 64'h0000_0000_0020_0180;
  localparam logic [63:0] M_CSR    = 64'h0000_0600_0000_0000;
  localparam logic [63:0] M_ECALL  = 64'h0000_0100_0000_0000;
  localparam logic [63:0] M_MRET   = 64'h0000_0800_0000_0000;
  localparam logic [63:0] M_EBREAK = 64'h0000_0000_0000_0004;
  localparam logic [63:0] M_BRANCH = 64'h0000_0000_F000_C000;
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic [1:0]  halt_code, halt_code_nxt;
  logic [63:0] mcycle, minstret;
  logic        retire;

  logic dec_illegal, dec_load, dec_store, dec_csr, dec_ecall, dec_mret, dec_ebreak, dec_nowb;
  logic cls_load, cls_store, cls_csr, cls_ecall, cls_mret, cls_nowb;

  // Multi-hot (including all-ones) is illegal.
  assign dec_illegal = |(bus.inst_type & (bus.inst_type - 64'd1));
  assign dec_load    = |(bus.inst_type & M_LOAD);
  assign dec_store   = |(bus.inst_type & M_STORE);
  assign dec_csr     = |(bus.inst_type & M_CSR);
  assign dec_ecall   = |(bus.inst_type & M_ECALL);
  assign dec_mret    = |(bus.inst_type & M_MRET);
  assign dec_ebreak  = |(bus.inst_type & M_EBREAK);
  assign dec_nowb    = dec_store | dec_ecall | dec_mret | dec_ebreak | (|(bus.inst_type & M_BRANCH));

  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    halt_code_nxt = halt_code;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.ifu_valid) begin
          state_nxt = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt     = S_HALT;
          halt_code_nxt = 2'b11;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_nxt     = S_HALT;
          halt_code_nxt = 2'b10;
        end else if (dec_ebreak) begin
          state_nxt     = S_HALT;
          halt_code_nxt = 2'b01;
        end else if (dec_ecall || dec_mret) begin
          state_nxt = S_TRAP;
        end else if (dec_load || dec_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (bus.lsu_done) begin
          state_nxt = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt     = S_HALT;
          halt_code_nxt = 2'b11;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) wait_nxt = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 8'd0;
      halt_code <= 2'b00;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      halt_code <= halt_code_nxt;
    end
  end

  // Class is frozen at the end of DECODE; later inst_type changes have no effect.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) begin
      cls_load  <= dec_load;
      cls_store <= dec_store;
      cls_csr   <= dec_csr;
      cls_ecall <= dec_ecall;
      cls_mret  <= dec_mret;
      cls_nowb  <= dec_nowb;
    end
  end

  assign retire = (state == S_WB) || (state == S_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else begin
      if (state != S_HALT) mcycle <= mcycle + 64'd1;
      if (retire)          minstret <= minstret + 64'd1;
    end
  end

  always_comb begin
    bus.ifu_req       = (state == S_FETCH);
    bus.inst_latch_en = (state == S_FETCH) & bus.ifu_valid;
    bus.lsu_req       = (state == S_MEM);
    bus.lsu_wen       = (state == S_MEM) & cls_store;
    bus.reg_wen       = (state == S_WB) & ~cls_nowb;
    bus.csr_wen       = (state == S_WB) & cls_csr;
    bus.pc_wen        = retire;
    bus.intr          = (state == S_TRAP) & cls_ecall;
    bus.mret          = (state == S_TRAP) & cls_mret;
    bus.halt          = (state == S_HALT);
    bus.halt_code     = halt_code;
    bus.state         = state;
    bus.mcycle        = mcycle;
    bus.minstret      = minstret;
  end

  // cls_load is kept for trace visibility alongside the other class bits.
  logic unused_cls;
  assign unused_cls = cls_load;

endmodule
